// File: rtl/oam_dma.sv
// oam_dma: bus-master copy of one source page into sprite
// attribute memory, triggered by a CPU write of the page byte.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_cpu_addr/wr/rd    CPU register decode and strobes
//   i_cpu_wdata         page byte written to the DMA register
//   o_cpu_rdata(_en)    page readback, one cycle after the read
//   o_bus_req, i_bus_gnt  bus ownership handshake
//   o_bus_addr/rd/wr    master address and strobes
//   o_bus_wdata         byte written into OAM
//   i_bus_rdata         read data, valid the cycle after a read
//   o_busy, o_done      transfer active / completion pulse
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wr,
  input  logic        i_cpu_rd,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_rdata_en,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX =
    8'(XFER_LEN - 1);

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_src_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic [15:0] r_addr;
  logic        r_req;
  logic        r_busy;
  logic        r_rd;
  logic        r_wr;
  logic        r_done;
  logic        r_rd_done;
  logic [7:0]  r_rdata;
  logic        r_rdata_en;

  logic        w_hit;
  logic        w_reg_wr;
  logic        w_reg_rd;
  logic [7:0]  w_eff_page;
  logic [15:0] w_src;
  logic [15:0] w_dst;
  logic [7:0]  w_nxt_idx;
  logic        w_last;

  assign w_hit    = (i_cpu_addr == DMA_REG_ADDR);
  assign w_reg_wr = i_cpu_wr && w_hit;
  assign w_reg_rd = i_cpu_rd && w_hit;

  // Pages E0..FF alias the work RAM echo region.
  assign w_eff_page = (i_cpu_wdata >= 8'hE0)
                    ? i_cpu_wdata - 8'h20
                    : i_cpu_wdata;

  assign w_src     = {r_src_page, r_idx};
  assign w_dst     = OAM_BASE + {8'h00, r_idx};
  assign w_nxt_idx = r_idx + 8'd1;
  assign w_last    = (r_idx == LAST_IDX);

  // Strobes are gated by the live grant so a
  // dropped grant silences the bus immediately.
  assign o_bus_rd    = r_rd && i_bus_gnt;
  assign o_bus_wr    = r_wr && i_bus_gnt;
  assign o_bus_req   = r_req;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  assign o_cpu_rdata    = r_rdata;
  assign o_cpu_rdata_en = r_rdata_en;

  // Read data arrives the cycle after a strobe
  // that actually reached the bus; capture it
  // then, even if LATCH is stalled by the grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_done <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_rd_done <= o_bus_rd;
      if (r_rd_done) begin
        r_data <= i_bus_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_page     <= 8'h00;
      r_src_page <= 8'h00;
      r_idx      <= 8'h00;
      r_addr     <= 16'h0000;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A register write starts or restarts from
      // any state, overriding a final WRITE.
      if (w_reg_wr) begin
        r_page     <= i_cpu_wdata;
        r_src_page <= w_eff_page;
        r_idx      <= 8'h00;
        r_state    <= S_REQ;
        r_req      <= 1'b1;
        r_busy     <= 1'b1;
        r_rd       <= 1'b0;
        r_wr       <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_req  <= 1'b0;
            r_busy <= 1'b0;
          end
          S_REQ: begin
            if (i_bus_gnt) begin
              r_state <= S_READ;
              r_rd    <= 1'b1;
              r_addr  <= w_src;
            end
          end
          S_READ: begin
            if (i_bus_gnt) begin
              r_state <= S_LATCH;
              r_rd    <= 1'b0;
            end
          end
          S_LATCH: begin
            if (i_bus_gnt) begin
              r_state <= S_WRITE;
              r_wr    <= 1'b1;
              r_addr  <= w_dst;
            end
          end
          S_WRITE: begin
            if (i_bus_gnt) begin
              r_wr <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_READ;
                r_idx   <= w_nxt_idx;
                r_rd    <= 1'b1;
                r_addr  <= {r_src_page, w_nxt_idx};
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Readback reports the raw page; no side effect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata    <= 8'h00;
      r_rdata_en <= 1'b0;
    end else begin
      r_rdata_en <= w_reg_rd;
      r_rdata    <= w_reg_rd ? r_page : 8'h00;
    end
  end

endmodule
